// File: rtl/adc_sample_filter.sv
// Boxcar moving average over 2^LOG2_DEPTH XADC codes with a hysteresis alarm.
// One-cycle latency from the sample strobe to avg_out/alarm_out; no backpressure.
module adc_sample_filter #(
  parameter int          LOG2_DEPTH = 3,
  parameter logic [11:0] HI_THRESH  = 12'hC00,
  parameter logic [11:0] LO_THRESH  = 12'hA00
) (
  input  logic        dclk_in,
  input  logic        reset_in,
  input  logic [15:0] sample_in,
  input  logic        sample_valid_in,
  input  logic        clear_in,
  output logic [11:0] avg_out,
  output logic        avg_valid_out,
  output logic        alarm_out,
  output logic [15:0] sample_count_out,
  output logic        dropped_out
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 12 + LOG2_DEPTH;

  typedef enum logic [1:0] {FLUSH, PRIME, RUN} state_t;

  state_t                state, state_nxt;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] fill;
  logic [SW-1:0]         sum;
  logic [SW-1:0]         next_sum;
  logic [11:0]           sample_buf [DEPTH];
  logic [11:0]           code;
  logic [11:0]           new_avg;
  logic                  accept;
  logic                  last_fill;
  logic                  avg_upd;
  logic                  alarm_nxt;
  logic                  unused_lsbs;

  assign code        = sample_in[15:4];
  assign unused_lsbs = ^sample_in[3:0];
  assign accept      = sample_valid_in && !clear_in && (state != FLUSH);
  assign last_fill   = (fill == LOG2_DEPTH'(DEPTH - 1));
  // Oldest entry leaves the window as the new code enters it.
  assign next_sum    = sum + SW'(code) - SW'(sample_buf[wr_ptr]);
  assign new_avg     = next_sum[SW-1:LOG2_DEPTH];

  always_comb begin
    state_nxt = state;
    avg_upd   = 1'b0;
    if (clear_in) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        FLUSH: if (wr_ptr == LOG2_DEPTH'(DEPTH - 1)) state_nxt = PRIME;
        PRIME: if (accept && last_fill) begin
          state_nxt = RUN;
          avg_upd   = 1'b1;
        end
        RUN:   avg_upd = accept;
        default: state_nxt = FLUSH;
      endcase
    end
  end

  always_comb begin
    alarm_nxt = alarm_out;
    if (!alarm_out && (new_avg >= HI_THRESH))
      alarm_nxt = 1'b1;
    else if (alarm_out && (new_avg <= LO_THRESH))
      alarm_nxt = 1'b0;
  end

  always_ff @(posedge dclk_in) begin
    if (reset_in) begin
      state            <= FLUSH;
      wr_ptr           <= '0;
      fill             <= '0;
      sum              <= '0;
      avg_out          <= '0;
      avg_valid_out    <= 1'b0;
      alarm_out        <= 1'b0;
      sample_count_out <= '0;
      dropped_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      avg_valid_out <= avg_upd;
      dropped_out   <= sample_valid_in && (clear_in || (state == FLUSH));
      if (clear_in) begin
        wr_ptr           <= '0;
        fill             <= '0;
        sum              <= '0;
        avg_out          <= '0;
        alarm_out        <= 1'b0;
        sample_count_out <= '0;
      end else if (state == FLUSH) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (accept) begin
        sum    <= next_sum;
        wr_ptr <= wr_ptr + 1'b1;
        if (state == PRIME)
          fill <= last_fill ? '0 : fill + 1'b1;
        if (sample_count_out != 16'hFFFF)
          sample_count_out <= sample_count_out + 16'd1;
        if (avg_upd) begin
          avg_out   <= new_avg;
          alarm_out <= alarm_nxt;
        end
      end
    end
  end

  // Window storage has no reset; FLUSH zeroes every entry before use.
  always_ff @(posedge dclk_in) begin
    if (!reset_in) begin
      if (state == FLUSH)
        sample_buf[wr_ptr] <= '0;
      else if (accept)
        sample_buf[wr_ptr] <= code;
    end
  end

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed bench for adc_sample_filter: vector table for the averaging/alarm walk plus flush, clear and reset sequences.
module tb_adc_sample_filter;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        clear_in;
  logic [11:0] avg_out;
  logic        avg_valid_out;
  logic        alarm_out;
  logic [15:0] sample_count_out;
  logic        dropped_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adc_sample_filter dut (
    .dclk_in          (clk),
    .reset_in         (reset_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .clear_in         (clear_in),
    .avg_out          (avg_out),
    .avg_valid_out    (avg_valid_out),
    .alarm_out        (alarm_out),
    .sample_count_out (sample_count_out),
    .dropped_out      (dropped_out)
  );

  typedef struct {
    logic [15:0] sample;
    logic        exp_valid;
    logic [11:0] exp_avg;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic apply(input logic [15:0] s, input logic v, input logic c);
    sample_in       = s;
    sample_valid_in = v;
    clear_in        = c;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{16'h8000, (i == 7), 12'h000 | ((i == 7) ? 12'h800 : 12'h000), 1'b0};
    vecs[8]  = '{16'hD000, 1'b1, 12'h8A0, 1'b0};
    vecs[9]  = '{16'hD000, 1'b1, 12'h940, 1'b0};
    vecs[10] = '{16'hD000, 1'b1, 12'h9E0, 1'b0};
    vecs[11] = '{16'hD000, 1'b1, 12'hA80, 1'b0};
    vecs[12] = '{16'hD000, 1'b1, 12'hB20, 1'b0};
    vecs[13] = '{16'hD000, 1'b1, 12'hBC0, 1'b0};
    vecs[14] = '{16'hD000, 1'b1, 12'hC60, 1'b1};
    vecs[15] = '{16'hD000, 1'b1, 12'hD00, 1'b1};
    vecs[16] = '{16'hB000, 1'b1, 12'hCC0, 1'b1};
    vecs[17] = '{16'hB000, 1'b1, 12'hC80, 1'b1};
    vecs[18] = '{16'hB000, 1'b1, 12'hC40, 1'b1};
    vecs[19] = '{16'hB000, 1'b1, 12'hC00, 1'b1};
    vecs[20] = '{16'hB000, 1'b1, 12'hBC0, 1'b1};
    vecs[21] = '{16'hB000, 1'b1, 12'hB80, 1'b1};
    vecs[22] = '{16'hB000, 1'b1, 12'hB40, 1'b1};
    vecs[23] = '{16'hB000, 1'b1, 12'hB00, 1'b1};
    vecs[24] = '{16'h9000, 1'b1, 12'hAC0, 1'b1};
    vecs[25] = '{16'h9000, 1'b1, 12'hA80, 1'b1};
    vecs[26] = '{16'h9000, 1'b1, 12'hA40, 1'b1};
    vecs[27] = '{16'h9000, 1'b1, 12'hA00, 1'b0};

    reset_in        = 1'b1;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    clear_in        = 1'b0;
    @(negedge clk);
    apply(16'h8000, 1'b1, 1'b0);
    apply(16'h8000, 1'b1, 1'b0);
    check("reset_avg", avg_out, 0);
    check("reset_valid", avg_valid_out, 0);
    check("reset_alarm", alarm_out, 0);
    check("reset_count", sample_count_out, 0);
    check("reset_dropped", dropped_out, 0);

    // Averaging and hysteresis walk
    reset_in = 1'b0;
    for (int i = 0; i < 8; i++) apply(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) begin
      apply(vecs[i].sample, 1'b1, 1'b0);
      check($sformatf("vec%0d_valid", i), avg_valid_out, vecs[i].exp_valid);
      check($sformatf("vec%0d_avg", i), avg_out, vecs[i].exp_avg);
      check($sformatf("vec%0d_alarm", i), alarm_out, vecs[i].exp_alarm);
      check($sformatf("vec%0d_count", i), sample_count_out, i + 1);
      check($sformatf("vec%0d_dropped", i), dropped_out, 0);
    end
    apply(16'h0000, 1'b0, 1'b0);
    check("idle_valid", avg_valid_out, 0);
    check("idle_avg_hold", avg_out, 12'hA00);

    // Strobes during the post-reset flush are dropped
    reset_in = 1'b1;
    apply(16'h0000, 1'b0, 1'b0);
    apply(16'h0000, 1'b0, 1'b0);
    reset_in = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      apply(16'h8000, (c == 1 || c == 4 || c == 8), 1'b0);
      check($sformatf("flush_drop_c%0d", c), dropped_out, (c == 1 || c == 4 || c == 8));
      check($sformatf("flush_count_c%0d", c), sample_count_out, 0);
    end
    for (int i = 0; i < 8; i++) begin
      apply(16'h8000, 1'b1, 1'b0);
      check($sformatf("prime_drop%0d", i), dropped_out, 0);
      check($sformatf("prime_count%0d", i), sample_count_out, i + 1);
      check($sformatf("prime_valid%0d", i), avg_valid_out, (i == 7));
    end
    check("prime_avg", avg_out, 12'h800);

    // Clear with a coincident strobe, then re-flush and re-prime
    apply(16'h8000, 1'b1, 1'b1);
    check("clr_dropped", dropped_out, 1);
    check("clr_avg", avg_out, 0);
    check("clr_alarm", alarm_out, 0);
    check("clr_count", sample_count_out, 0);
    check("clr_valid", avg_valid_out, 0);
    for (int i = 0; i < 8; i++) begin
      apply(16'hD000, 1'b1, 1'b0);
      check($sformatf("clr_flush_drop%0d", i), dropped_out, 1);
      check($sformatf("clr_flush_count%0d", i), sample_count_out, 0);
    end
    for (int i = 0; i < 8; i++) begin
      apply(16'hD000, 1'b1, 1'b0);
      check($sformatf("clr_prime_valid%0d", i), avg_valid_out, (i == 7));
    end
    check("clr_prime_avg", avg_out, 12'hD00);
    check("clr_prime_alarm", alarm_out, 1);

    // clear_in held: flush only starts once it drops
    for (int i = 0; i < 3; i++) apply(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      apply(16'h9000, 1'b1, 1'b0);
      check($sformatf("held_flush_drop%0d", i), dropped_out, 1);
    end
    apply(16'h9000, 1'b1, 1'b0);
    check("held_first_accept_drop", dropped_out, 0);
    check("held_first_accept_count", sample_count_out, 1);

    // Back-to-back strobes, low bits ignored
    apply(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) apply(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      apply((i % 2 == 0) ? 16'h800F : 16'h8000, 1'b1, 1'b0);
      check($sformatf("b2b_valid%0d", i), avg_valid_out, (i >= 7));
      check($sformatf("b2b_count%0d", i), sample_count_out, i + 1);
      if (i >= 7) check($sformatf("b2b_avg%0d", i), avg_out, 12'h800);
    end

    // Reset beats a coincident strobe and suppresses dropped_out
    reset_in = 1'b1;
    apply(16'h8000, 1'b1, 1'b0);
    check("rst_win_dropped", dropped_out, 0);
    check("rst_win_count", sample_count_out, 0);
    check("rst_win_avg", avg_out, 0);
    check("rst_win_valid", avg_valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_filter.md
Name: adc_sample_filter

Overview:
- Sits directly downstream of the XADC DRP read wrapper and consumes its 16-bit conversion word plus a one-cycle valid strobe (drdy-derived).
- Computes a boxcar moving average over 2^LOG2_DEPTH samples using a circular buffer and a running sum.
- Applies a hysteresis threshold to the average and raises a level alarm for the core's interrupt and status logic.
- Reports accepted-sample and dropped-sample activity.

Parameters:
- LOG2_DEPTH, 3, log2 of averaging window; DEPTH = 2^LOG2_DEPTH entries (legal range 1..6).
- HI_THRESH, 12'hC00, alarm set level; alarm sets when avg >= HI_THRESH.
- LO_THRESH, 12'hA00, alarm clear level; alarm clears when avg <= LO_THRESH. Must be < HI_THRESH.

Ports:
- dclk_in  input  1  clock, same domain as the XADC DRP clock.
- reset_in  input  1  reset.
- sample_in  input  16  XADC result word; code = sample_in[15:4], bits [3:0] ignored.
- sample_valid_in  input  1  one-cycle strobe; sample_in is valid in that cycle.
- clear_in  input  1  synchronous flush request.
- avg_out  output  12  current window average.
- avg_valid_out  output  1  one-cycle pulse on each avg_out update.
- alarm_out  output  1  hysteresis threshold alarm (level).
- sample_count_out  output  16  accepted samples since reset/clear, saturating at 16'hFFFF.
- dropped_out  output  1  one-cycle pulse when a valid sample is discarded.

Behaviour:
- Clock and reset: one clock, dclk_in. reset_in is synchronous and active-high.
- Reset state: state=FLUSH, wr_ptr=0, fill=0, sum=0, avg_out=0, avg_valid_out=0, alarm_out=0, sample_count_out=0, dropped_out=0.
- FLUSH state:
  - Writes 0 to buf[wr_ptr] and increments wr_ptr each cycle, for exactly DEPTH cycles after reset_in or clear_in deasserts.
  - When wr_ptr wraps to 0, goes to PRIME.
  - Any sample_valid_in seen in FLUSH is discarded and pulses dropped_out on the next cycle.
- PRIME and RUN, on each sample_valid_in:
  - next_sum = sum + code - buf[wr_ptr] (sum width 12+LOG2_DEPTH, never overflows).
  - buf[wr_ptr] <= code; wr_ptr <= wr_ptr+1 (wraps modulo DEPTH); sample_count_out increments (saturating).
- PRIME: fill counts accepted samples. The DEPTH-th accepted sample moves the block to RUN and produces the first avg_valid_out pulse. Samples before that produce no avg_valid_out.
- RUN: every accepted sample updates avg_out.
  - avg_out <= next_sum >> LOG2_DEPTH (truncating), registered at the same edge that accepts the sample.
  - Latency: avg_out and avg_valid_out are valid 1 cycle after the sample_valid_in cycle.
- Alarm:
  - Evaluated only on avg updates, from the new average, and registered together with avg_out.
  - If alarm=0 and new_avg >= HI_THRESH, set. If alarm=1 and new_avg <= LO_THRESH, clear. Otherwise hold.
- Throughput: sample_valid_in may be asserted every cycle; no backpressure.
- clear_in:
  - Next state is FLUSH; sum, fill, wr_ptr, avg_out, alarm_out and sample_count_out are cleared at that edge.
  - Held high: stays in FLUSH with wr_ptr held at 0. The DEPTH-cycle flush starts when clear_in drops.
- Simultaneous events:
  - clear_in wins over sample_valid_in; the sample is dropped and dropped_out pulses.
  - reset_in wins over everything; dropped_out is not pulsed during reset.
- Reset or clear mid-window: the partial window is discarded; averaging restarts from an empty window (full PRIME required).
- The buffer may be inferred as distributed RAM with one synchronous write port and one asynchronous read port at wr_ptr.

Test Plan (defaults: DEPTH=8, HI=0xC00, LO=0xA00):
1. Release reset, wait 8 cycles, then send 8 strobes of 16'h8000 → no avg_valid_out for strobes 1-7. One cycle after strobe 8: avg_valid_out=1, avg_out=0x800, alarm_out=0, sample_count_out=8.
2. Continue with 16'hD000 strobes → avg_out steps 0x8A0, 0x940, … The 6th strobe gives 0xBC0 (alarm 0). The 7th gives 0xC60 and alarm_out=1. The 8th gives 0xD00.
3. Then 8 strobes of 16'hB000 → avg_out falls to 0xB00 and alarm stays 1 (hysteresis). Next, 16'h9000 strobes give 0xAC0, 0xA80, 0xA40, 0xA00; alarm_out clears on the 4th.
4. Assert sample_valid_in on cycles 1, 4 and 8 after reset release → dropped_out pulses three times, sample_count_out=0, state reaches PRIME on cycle 8.
5. In RUN, assert clear_in and sample_valid_in together → dropped_out=1, then avg_out=0, alarm_out=0, count=0. The next 8 cycles drop strobes; 8 fresh samples are then required before avg_valid_out.
6. Send back-to-back strobes every cycle alternating 16'h800F and 16'h8000 → after priming, avg_out=0x800 every cycle with avg_valid_out continuously high. Low bits are ignored; no sample is lost.
